// File: rtl/blockade_pkg.sv
// Shared types and constants for the Blockade colour-overlay stage.
// The mask encoding is {B,G,R}, one bit per gun.
package blockade_pkg;

  localparam int H_ACTIVE   = 256;
  localparam int V_ACTIVE   = 224;
  localparam int BAND_LINES = 16;
  localparam logic [2:0] BAND_MASK = 3'b111;

  typedef enum logic [1:0] {
    OVL_GREEN  = 2'd0,
    OVL_WHITE  = 2'd1,
    OVL_YELLOW = 2'd2,
    OVL_RED    = 2'd3
  } overlay_t;

  localparam logic [2:0] MASK_GREEN  = 3'b010;
  localparam logic [2:0] MASK_WHITE  = 3'b111;
  localparam logic [2:0] MASK_YELLOW = 3'b011;
  localparam logic [2:0] MASK_RED    = 3'b001;

  function automatic logic [2:0] ovl_mask(input overlay_t ovl);
    logic [2:0] m;
    case (ovl)
      OVL_GREEN:  m = MASK_GREEN;
      OVL_WHITE:  m = MASK_WHITE;
      OVL_YELLOW: m = MASK_YELLOW;
      OVL_RED:    m = MASK_RED;
      default:    m = MASK_GREEN;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/blockade_beam_counter.sv
// Beam position tracking: saturating h/v counters, blank edge detectors
// and the one-clock frame_start pulse on the vblank rising edge.
module blockade_beam_counter
  import blockade_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       hblank,
  input  logic       vblank,
  output logic [7:0] vcount,
  output logic       vblank_rise,
  output logic       frame_start
);

  localparam logic [8:0] H_MAX = 9'(H_ACTIVE - 1);
  localparam logic [7:0] V_MAX = 8'(V_ACTIVE - 1);

  logic [8:0] hcount_r;
  logic [7:0] vcount_r;
  logic       hblank_d_r;
  logic       vblank_d_r;
  logic       frame_start_r;
  logic       hblank_rise_s;

  assign hblank_rise_s = hblank & ~hblank_d_r;
  assign vblank_rise   = vblank & ~vblank_d_r;
  assign vcount        = vcount_r;
  assign frame_start   = frame_start_r;

  // Edge detectors reset to "blanking" so a vblank already high at reset
  // release is not mistaken for a new frame.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcount_r      <= 9'd0;
      vcount_r      <= 8'd0;
      hblank_d_r    <= 1'b1;
      vblank_d_r    <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= ce_pix & vblank_rise;
      if (ce_pix) begin
        hblank_d_r <= hblank;
        vblank_d_r <= vblank;
        if (hblank) begin
          hcount_r <= 9'd0;
        end else if (hcount_r != H_MAX) begin
          hcount_r <= hcount_r + 9'd1;
        end else begin
          hcount_r <= hcount_r;
        end
        if (vblank) begin
          vcount_r <= 8'd0;
        end else if (hblank_rise_s && (vcount_r != V_MAX)) begin
          vcount_r <= vcount_r + 8'd1;
        end else begin
          vcount_r <= vcount_r;
        end
      end
    end
  end

endmodule

// File: rtl/blockade_overlay.sv
// Pixel-rate cellophane overlay: tints monochrome video with a frame-latched
// colour mask and an optional white score band over the top lines.
module blockade_overlay
  import blockade_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       vid,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [1:0] overlay_type,
  input  logic       zoned,
  output logic [2:0] rgb,
  output logic       hb_out,
  output logic       vb_out,
  output logic       frame_start
);

  localparam logic [8:0] BAND_LIM = 9'(BAND_LINES);

  logic [7:0] vcount_s;
  logic       vblank_rise_s;
  logic [2:0] sel_mask_s;
  logic [2:0] mask_r;
  logic       zoned_r;
  logic [2:0] rgb_r;
  logic       hb_r;
  logic       vb_r;

  blockade_beam_counter u_beam (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .hblank      (hblank),
    .vblank      (vblank),
    .vcount      (vcount_s),
    .vblank_rise (vblank_rise_s),
    .frame_start (frame_start)
  );

  // Score band overrides the frame colour on the top lines when zoned.
  always_comb begin
    sel_mask_s = mask_r;
    if (zoned_r && ({1'b0, vcount_s} < BAND_LIM)) begin
      sel_mask_s = BAND_MASK;
    end else begin
      sel_mask_s = mask_r;
    end
  end

  // Frame latch and one-ce_pix output register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mask_r  <= MASK_GREEN;
      zoned_r <= 1'b0;
      rgb_r   <= 3'b000;
      hb_r    <= 1'b1;
      vb_r    <= 1'b1;
    end else if (ce_pix) begin
      if (vblank_rise_s) begin
        mask_r  <= ovl_mask(overlay_t'(overlay_type));
        zoned_r <= zoned;
      end
      rgb_r <= (vid & ~hblank & ~vblank) ? sel_mask_s : 3'b000;
      hb_r  <= hblank;
      vb_r  <= vblank;
    end
  end

  assign rgb    = rgb_r;
  assign hb_out = hb_r;
  assign vb_out = vb_r;

endmodule

// File: tb/tb_blockade_overlay.sv
// Scoreboard bench for blockade_overlay: stimulus pushes expected pixels,
// a forked monitor pops and compares after every accepted ce_pix.
module tb_blockade_overlay;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic       vid = 1'b0;
  logic       hblank = 1'b1;
  logic       vblank = 1'b1;
  logic [1:0] overlay_type = 2'd0;
  logic       zoned = 1'b0;
  logic [2:0] rgb;
  logic       hb_out;
  logic       vb_out;
  logic       frame_start;

  always #5 clk_sys = ~clk_sys;

  blockade_overlay dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_pix       (ce_pix),
    .vid          (vid),
    .hblank       (hblank),
    .vblank       (vblank),
    .overlay_type (overlay_type),
    .zoned        (zoned),
    .rgb          (rgb),
    .hb_out       (hb_out),
    .vb_out       (vb_out),
    .frame_start  (frame_start)
  );

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int fs0 = 0;
  int gap = 1;
  int hist [8];
  logic [4:0] exp_q [$];

  logic [8:0] m_h;
  logic [7:0] m_v;
  logic       m_hbd, m_vbd, m_zoned;
  logic [2:0] m_mask;

  function automatic logic [2:0] ref_mask(input logic [1:0] t);
    logic [2:0] m;
    case (t)
      2'd0:    m = 3'b010;
      2'd1:    m = 3'b111;
      2'd2:    m = 3'b011;
      default: m = 3'b001;
    endcase
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 9'd0; m_v = 8'd0; m_hbd = 1'b1; m_vbd = 1'b1;
    m_mask = 3'b010; m_zoned = 1'b0;
  endtask

  task automatic hclear();
    for (int i = 0; i < 8; i++) hist[i] = 0;
  endtask

  task automatic monitor();
    logic cap;
    logic [4:0] e;
    forever begin
      @(posedge clk_sys);
      cap = ce_pix && !reset;
      @(negedge clk_sys);
      if (frame_start) fs_cnt++;
      if (cap) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pix_underflow actual=%b%b%b expected=none", rgb, hb_out, vb_out);
        end else begin
          e = exp_q.pop_front();
          if ({rgb, hb_out, vb_out} != e) begin
            errors++;
            $display("FAIL pix rgb_hb_vb actual=%b expected=%b", {rgb, hb_out, vb_out}, e);
          end
          if (rgb != 3'b000) hist[rgb]++;
        end
      end
    end
  endtask

  // One ce_pix with the given inputs; called at posedge+1.
  task automatic pix(input logic v, input logic hb, input logic vb);
    logic vr, hr;
    logic [2:0] sel;
    vid = v; hblank = hb; vblank = vb; ce_pix = 1'b1;
    vr  = vb & ~m_vbd;
    hr  = hb & ~m_hbd;
    sel = (m_zoned && (m_v < 8'd16)) ? 3'b111 : m_mask;
    exp_q.push_back({(v & ~hb & ~vb) ? sel : 3'b000, hb, vb});
    if (vr) begin m_mask = ref_mask(overlay_type); m_zoned = zoned; end
    if (hb) m_h = 9'd0; else if (m_h != 9'd255) m_h = m_h + 9'd1;
    if (vb) m_v = 8'd0; else if (hr && (m_v != 8'd223)) m_v = m_v + 8'd1;
    m_hbd = hb; m_vbd = vb;
    @(posedge clk_sys); #1;
    ce_pix = 1'b0;
    for (int i = 1; i < gap; i++) begin @(posedge clk_sys); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; ce_pix = 1'b1; vid = 1'b1; hblank = 1'b0; vblank = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b0; ce_pix = 1'b0;
    model_reset();
    check("rst_rgb", int'(rgb), 0);
    check("rst_hb", int'(hb_out), 1);
    check("rst_vb", int'(vb_out), 1);
    check("rst_hcount", int'(dut.u_beam.hcount_r), 0);
    check("rst_vcount", int'(dut.u_beam.vcount_r), 0);
    check("rst_fs", int'(frame_start), 0);
  endtask

  task automatic drain();
    @(negedge clk_sys); @(posedge clk_sys); #1;
  endtask

  // Two vblank lines, then active lines of npix lit pixels plus 2 hblank.
  task automatic run_frame(input int lines, input int npix, input int chg_line,
                           input logic [1:0] chg_ot, input logic chg_z,
                           input int rst_line, input int rst_pix);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < npix; p++) pix(1'b1, 1'b0, 1'b1);
      pix(1'b0, 1'b1, 1'b1); pix(1'b0, 1'b1, 1'b1);
    end
    for (int l = 0; l < lines; l++) begin
      if (l == chg_line) begin overlay_type = chg_ot; zoned = chg_z; end
      for (int p = 0; p < npix; p++) begin
        if (l == rst_line && p == rst_pix) do_reset();
        pix(1'b1, 1'b0, 1'b0);
      end
      pix(1'b0, 1'b1, 1'b0); pix(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    hclear();
    fork monitor(); join_none
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    check("init_rgb", int'(rgb), 0);
    check("init_hb", int'(hb_out), 1);
    check("init_vb", int'(vb_out), 1);
    check("init_fs", int'(frame_start), 0);
    check("init_hcount", int'(dut.u_beam.hcount_r), 0);
    check("init_vcount", int'(dut.u_beam.vcount_r), 0);

    // Green frame with ce_pix every 4th clock.
    gap = 4;
    pix(1'b0, 1'b1, 1'b0);
    hclear(); fs0 = fs_cnt;
    run_frame(8, 8, -1, 2'd0, 1'b0, -1, -1);
    drain();
    check("green_px", hist[2], 64);
    check("green_other", hist[1] + hist[3] + hist[7], 0);
    check("green_fs", fs_cnt - fs0, 1);
    gap = 1;

    // Mid-frame change to red has no effect until the next frame.
    hclear(); fs0 = fs_cnt;
    run_frame(110, 4, 100, 2'd3, 1'b0, -1, -1);
    drain();
    check("midchg_green", hist[2], 440);
    check("midchg_red", hist[1], 0);
    check("midchg_fs", fs_cnt - fs0, 1);
    hclear(); fs0 = fs_cnt;
    run_frame(10, 4, -1, 2'd0, 1'b0, -1, -1);
    drain();
    check("red_px", hist[1], 40);
    check("red_fs", fs_cnt - fs0, 1);

    // Zoned yellow: 16 white band lines, then yellow.
    overlay_type = 2'd2; zoned = 1'b1;
    hclear();
    run_frame(20, 4, -1, 2'd0, 1'b0, -1, -1);
    drain();
    check("band_white", hist[7], 64);
    check("band_yellow", hist[3], 16);
    zoned = 1'b0;
    hclear();
    run_frame(20, 4, -1, 2'd0, 1'b0, -1, -1);
    drain();
    check("noband_yellow", hist[3], 80);
    check("noband_white", hist[7], 0);

    // vblank and hblank rise together: latch happens, vcount clears.
    pix(1'b1, 1'b0, 1'b0);
    overlay_type = 2'd1; fs0 = fs_cnt;
    pix(1'b0, 1'b1, 1'b1);
    drain();
    check("simul_vcount", int'(dut.u_beam.vcount_r), 0);
    check("simul_fs", fs_cnt - fs0, 1);
    hclear();
    pix(1'b0, 1'b1, 1'b0);
    repeat (3) pix(1'b1, 1'b0, 1'b0);
    drain();
    check("simul_white", hist[7], 3);

    // Counter saturation.
    pix(1'b0, 1'b1, 1'b0);
    repeat (300) pix(1'b1, 1'b0, 1'b0);
    check("hsat", int'(dut.u_beam.hcount_r), 255);
    pix(1'b0, 1'b1, 1'b0);
    check("hclr", int'(dut.u_beam.hcount_r), 0);
    repeat (250) begin pix(1'b1, 1'b0, 1'b0); pix(1'b0, 1'b1, 1'b0); end
    check("vsat", int'(dut.u_beam.vcount_r), 223);
    pix(1'b0, 1'b0, 1'b1);
    check("vclr", int'(dut.u_beam.vcount_r), 0);
    pix(1'b0, 1'b1, 1'b0);

    // Reset at line 50, pixel 80 of a red frame; mask falls back to green.
    overlay_type = 2'd3; zoned = 1'b0;
    hclear(); fs0 = fs_cnt;
    run_frame(60, 84, -1, 2'd0, 1'b0, 50, 80);
    drain();
    check("prerst_red", hist[1], 4280);
    check("postrst_green", hist[2], 760);
    check("rst_frame_fs", fs_cnt - fs0, 1);
    hclear();
    run_frame(2, 4, -1, 2'd0, 1'b0, -1, -1);
    drain();
    check("afterrst_red", hist[1], 8);
    check("afterrst_green", hist[2], 0);

    // ce_pix low for 100 clocks: nothing moves.
    pix(1'b0, 1'b1, 1'b0);
    pix(1'b1, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0);
    drain();
    fs0 = fs_cnt;
    for (int i = 0; i < 100; i++) begin
      vid = 1'($urandom); hblank = 1'($urandom); vblank = 1'($urandom);
      @(posedge clk_sys); #1;
    end
    hblank = 1'b1; vblank = 1'b1;
    @(posedge clk_sys); #1;
    check("idle_rgb", int'(rgb), 1);
    check("idle_hb", int'(hb_out), 0);
    check("idle_vb", int'(vb_out), 0);
    check("idle_hcount", int'(dut.u_beam.hcount_r), 2);
    check("idle_vcount", int'(dut.u_beam.vcount_r), 2);
    check("idle_fs", fs_cnt - fs0, 0);
    pix(1'b0, 1'b0, 1'b1);
    drain();
    check("wake_fs", fs_cnt - fs0, 1);
    check("wake_vcount", int'(dut.u_beam.vcount_r), 0);

    drain();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
